// File: rtl/rou_pkg.sv
// Shared codes and field layout for the ROU terminal receiver.
package rou_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_WR   = 2'b01,
    CMD_RD   = 2'b10,
    CMD_RRSP = 2'b11
  } rou_cmd_e;

  typedef enum logic [2:0] {
    ACK_NONE = 3'd0,
    ACK_ACC  = 3'd1,
    ACK_DROP = 3'd2
  } rou_ack_e;

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_FLUSH} rx_state_e;

  localparam int CMD_W   = 2;
  localparam int OFF_CMD = 0;
  localparam int OFF_TAG = OFF_CMD + CMD_W;

  function automatic int bwid_of(input int dwid);
    return (dwid == 512) ? 6 : (dwid == 256) ? 5 : (dwid == 128) ? 4 : (dwid == 64) ? 3 : 2;
  endfunction

  function automatic int off_bytes(input int twid);
    return OFF_TAG + twid;
  endfunction

  function automatic int off_addr(input int twid, input int bwid);
    return OFF_TAG + twid + bwid;
  endfunction

  function automatic int off_data(input int twid, input int bwid, input int awid);
    return OFF_TAG + twid + bwid + awid;
  endfunction

endpackage

// File: rtl/rou_terminal_rx_if.sv
// Sender/consumer bundle of the ROU terminal receiver.
interface rou_terminal_rx_if #(
  parameter int DWID = 128,
  parameter int AWID = 32,
  parameter int TWID = 5,
  parameter int BWID = rou_pkg::bwid_of(DWID),
  parameter int WID  = 2 + DWID + AWID + BWID + TWID
);
  logic [WID-1:0]  rou_in;
  logic            rou_in_seen;
  logic [2:0]      ack_out;
  logic            hold;
  logic            flush;
  logic            msg_valid;
  logic            msg_ready;
  logic [1:0]      msg_cmd;
  logic [TWID-1:0] msg_tag;
  logic [BWID-1:0] msg_bytes;
  logic [AWID-1:0] msg_addr;
  logic [DWID-1:0] msg_data;
  logic            msg_seen;

  modport master (
    output rou_in, rou_in_seen, hold, flush, msg_ready,
    input  ack_out, msg_valid, msg_cmd, msg_tag, msg_bytes, msg_addr, msg_data, msg_seen
  );

  modport slave (
    input  rou_in, rou_in_seen, hold, flush, msg_ready,
    output ack_out, msg_valid, msg_cmd, msg_tag, msg_bytes, msg_addr, msg_data, msg_seen
  );
endinterface

// File: rtl/rou_rx_fifo.sv
// Single-clock message buffer with registered full/empty and an occupancy count.
module rou_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_n;
  logic          do_push, do_pop;

  // Full/empty gate both ends, so a push on a full buffer is refused even alongside a pop.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    cnt_n = count;
    unique case ({do_push, do_pop})
      2'b10:   cnt_n = count + 1'b1;
      2'b01:   cnt_n = count - 1'b1;
      default: cnt_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_n;
      full  <= (cnt_n == CW'(DEPTH));
      empty <= (cnt_n == '0);
    end
  end
endmodule

// File: rtl/rou_terminal_rx.sv
// ROU terminal receiver: window filter, RUN/HOLD/FLUSH control, buffered delivery.
// Optional ROU_RX_STATS_EN adds saturating accept/drop counters.
module rou_terminal_rx import rou_pkg::*; #(
  parameter int             DWID  = 128,
  parameter int             AWID  = 32,
  parameter int             TWID  = 5,
  parameter int             BWID  = bwid_of(DWID),
  parameter int             WID   = 2 + DWID + AWID + BWID + TWID,
  parameter int             DEPTH = 4,
  parameter logic [AWID-1:0] BASE = '0,
  parameter logic [AWID-1:0] MASK = '0
) (
  input  logic clk,
  input  logic rst_n,
  rou_terminal_rx_if.slave bus
`ifdef ROU_RX_STATS_EN
  ,
  output logic [15:0] stat_acc,
  output logic [15:0] stat_drop
`endif
);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int OFF_B = off_bytes(TWID);
  localparam int OFF_A = off_addr(TWID, BWID);
  localparam int OFF_D = off_data(TWID, BWID, AWID);

  rx_state_e       state, state_n;
  rou_ack_e        ack;
  logic            offer, hit, push, pop, full, empty, msg_valid;
  logic [CW-1:0]   cnt;
  logic [WID:0]    head;
  logic [AWID-1:0] in_addr;

  assign in_addr = bus.rou_in[OFF_A +: AWID];
  assign offer   = (bus.rou_in[OFF_CMD +: CMD_W] != CMD_IDLE);
  assign hit     = (((in_addr ^ BASE) & MASK) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_n;
  end

  // ack depends only on the offer and registered state, never on msg_ready.
  always_comb begin
    state_n = state;
    ack     = ACK_NONE;
    push    = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (offer) begin
          if (!hit) begin
            ack = ACK_DROP;
          end else if (!full) begin
            ack  = ACK_ACC;
            push = 1'b1;
          end
        end
        state_n = bus.hold ? ST_HOLD : ST_RUN;
      end
      ST_HOLD:  state_n = bus.hold ? ST_HOLD : ST_RUN;
      // Leave once this cycle's discard empties the buffer.
      ST_FLUSH: if (cnt <= CW'(1)) state_n = bus.hold ? ST_HOLD : ST_RUN;
      default:  state_n = ST_RUN;
    endcase
    if (bus.flush) state_n = ST_FLUSH;
    if (!rst_n) begin
      ack  = ACK_NONE;
      push = 1'b0;
    end
  end

  assign msg_valid = !empty && (state != ST_FLUSH);
  assign pop       = (state == ST_FLUSH) ? !empty : (msg_valid && bus.msg_ready);

  rou_rx_fifo #(.W(WID + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.rou_in_seen, bus.rou_in}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );

  assign bus.ack_out   = ack;
  assign bus.msg_valid = msg_valid;
  assign bus.msg_cmd   = msg_valid ? head[OFF_CMD +: CMD_W] : '0;
  assign bus.msg_tag   = msg_valid ? head[OFF_TAG +: TWID]  : '0;
  assign bus.msg_bytes = msg_valid ? head[OFF_B +: BWID]    : '0;
  assign bus.msg_addr  = msg_valid ? head[OFF_A +: AWID]    : '0;
  assign bus.msg_data  = msg_valid ? head[OFF_D +: DWID]    : '0;
  assign bus.msg_seen  = msg_valid && head[WID];

`ifdef ROU_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_acc  <= '0;
      stat_drop <= '0;
    end else begin
      if (ack == ACK_ACC  && stat_acc  != 16'hFFFF) stat_acc  <= stat_acc + 1'b1;
      if (ack == ACK_DROP && stat_drop != 16'hFFFF) stat_drop <= stat_drop + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_rou_terminal_rx.sv
// Self-checking bench for rou_terminal_rx: vector table, directed corner sequences, random vs queue model.
module tb_rou_terminal_rx;
  import rou_pkg::*;

  localparam int DWID  = 128;
  localparam int AWID  = 32;
  localparam int TWID  = 5;
  localparam int BWID  = 4;
  localparam int WID   = 2 + DWID + AWID + BWID + TWID;
  localparam int DEPTH = 4;
  localparam int OFF_A = 2 + TWID + BWID;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] MASK = 32'hFFFF_F000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rou_terminal_rx_if #(.DWID(DWID), .AWID(AWID), .TWID(TWID), .BWID(BWID), .WID(WID)) bus();
`ifdef ROU_RX_STATS_EN
  logic [15:0] stat_acc, stat_drop;
`endif

  rou_terminal_rx #(
    .DWID(DWID), .AWID(AWID), .TWID(TWID), .BWID(BWID), .WID(WID),
    .DEPTH(DEPTH), .BASE(BASE), .MASK(MASK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ROU_RX_STATS_EN
    ,
    .stat_acc  (stat_acc),
    .stat_drop (stat_drop)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [WID:0] q[$];
  int           mode = 0;  // 0 run, 1 hold, 2 flush
  logic [2:0]   got_ack;
  logic         got_valid;
  logic [WID:0] got_head;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [2:0]  ack;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [WID-1:0] mk(input logic [1:0] c, input logic [31:0] a, input logic [4:0] t);
    logic [127:0] d;
    d = {a, ~a, a + 32'd1, 27'd0, t};
    return {d, a, 4'(t), t, c};
  endfunction

  function automatic logic [31:0] haddr(input logic [WID:0] h);
    return h[OFF_A +: AWID];
  endfunction

  // One clock: drive, sample, check against the queue model, advance the model.
  task automatic cyc(input logic [WID-1:0] m, input logic s, input logic h, input logic f,
                     input logic r, input logic rn);
    logic [2:0]  e_ack;
    logic        e_valid;
    logic [31:0] a;
    @(negedge clk);
    bus.rou_in = m; bus.rou_in_seen = s; bus.hold = h; bus.flush = f; bus.msg_ready = r;
    rst_n = rn;
    #1;
    got_ack   = bus.ack_out;
    got_valid = bus.msg_valid;
    got_head  = {bus.msg_seen, bus.msg_data, bus.msg_addr, bus.msg_bytes, bus.msg_tag, bus.msg_cmd};
    a = m[OFF_A +: AWID];
    e_ack = 3'd0;
    e_valid = 1'b0;
    if (rn) begin
      if (mode == 0 && m[1:0] != 2'b00)
        e_ack = (((a ^ BASE) & MASK) != 0) ? 3'd2 : ((q.size() < DEPTH) ? 3'd1 : 3'd0);
      e_valid = (q.size() > 0) && (mode != 2);
    end
    chk("model_ack", got_ack, e_ack);
    chk("model_valid", got_valid, e_valid);
    if (e_valid) chk("model_head", got_head, q[0]);
    if (!rn) begin
      q.delete();
      mode = 0;
    end else begin
      if ((mode == 2 && q.size() > 0) || (e_valid && r)) void'(q.pop_front());
      if (e_ack == 3'd1) q.push_back({s, m});
      if (f)              mode = 2;
      else if (mode == 2) mode = (q.size() == 0) ? (h ? 1 : 0) : 2;
      else                mode = h ? 1 : 0;
    end
  endtask

  initial begin
    logic [WID-1:0] m4, cur;
    logic           cur_s, hold_r, fl, rdy;
    bus.rou_in = '0; bus.rou_in_seen = 1'b0; bus.hold = 1'b0; bus.flush = 1'b0; bus.msg_ready = 1'b0;

    tbl[0] = '{2'b01, 32'h0000_1004, 3'd1};
    tbl[1] = '{2'b01, 32'h0000_2000, 3'd2};
    tbl[2] = '{2'b00, 32'h0000_1004, 3'd0};
    tbl[3] = '{2'b10, 32'h0000_1FFF, 3'd1};
    tbl[4] = '{2'b11, 32'h0000_0FFC, 3'd2};
    tbl[5] = '{2'b10, 32'h0000_1000, 3'd1};
    tbl[6] = '{2'b01, 32'hFFFF_1000, 3'd2};
    tbl[7] = '{2'b11, 32'h0000_1800, 3'd1};

    // reset state with a message on the wire
    cyc(mk(2'b01, 32'h1004, 5'd1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_ack", got_ack, 3'd0);
    chk("rst_valid", got_valid, 1'b0);
    chk("rst_addr", haddr(got_head), 32'h0);
    cyc('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // vector table, consumer always ready
    for (int i = 0; i < 8; i++) begin
      cyc(mk(tbl[i].cmd, tbl[i].addr, 5'(i)), 1'(i), 1'b0, 1'b0, 1'b1, 1'b1);
      chk("tbl_ack", got_ack, tbl[i].ack);
      if (i > 0) begin
        chk("tbl_valid", got_valid, tbl[i-1].ack == 3'd1);
        if (tbl[i-1].ack == 3'd1) chk("tbl_addr", haddr(got_head), tbl[i-1].addr);
      end
    end
    cyc('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("tbl_last_valid", got_valid, 1'b1);
    chk("tbl_last_addr", haddr(got_head), 32'h0000_1800);

    // full buffer, refused 5th, retry after one pop
    for (int k = 0; k < 4; k++) begin
      cyc(mk(2'b01, 32'h1100 + 32'(k * 4), 5'(8 + k)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("full_acc", got_ack, 3'd1);
    end
    m4 = mk(2'b01, 32'h1110, 5'd12);
    cyc(m4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full_ref", got_ack, 3'd0);
    cyc(m4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full_ref_held", got_ack, 3'd0);
    cyc(m4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("full_pop_ack", got_ack, 3'd0);
    chk("full_pop_addr", haddr(got_head), 32'h1100);
    cyc(m4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full_retry", got_ack, 3'd1);
    for (int k = 1; k < 5; k++) begin
      cyc('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("full_drain_valid", got_valid, 1'b1);
      chk("full_drain_addr", haddr(got_head), 32'h1100 + 32'(k * 4));
    end
    cyc('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("full_empty", got_valid, 1'b0);

    // hold with two entries buffered
    cyc(mk(2'b01, 32'h1200, 5'd1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(mk(2'b01, 32'h1204, 5'd2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(mk(2'b01, 32'h1208, 5'd3), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("hold_ack0", got_ack, 3'd0);
    chk("hold_drain0", haddr(got_head), 32'h1200);
    cyc(mk(2'b01, 32'h1208, 5'd3), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("hold_ack1", got_ack, 3'd0);
    chk("hold_drain1", haddr(got_head), 32'h1204);
    cyc(mk(2'b01, 32'h1208, 5'd3), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("hold_ack2", got_ack, 3'd0);
    chk("hold_empty", got_valid, 1'b0);
    cyc(mk(2'b01, 32'h1208, 5'd3), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("hold_resume", got_ack, 3'd1);
    cyc('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("hold_after", haddr(got_head), 32'h1208);

    // flush with three entries
    for (int k = 0; k < 3; k++)
      cyc(mk(2'b10, 32'h1300 + 32'(k * 4), 5'(k)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(mk(2'b01, 32'h130C, 5'd7), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("flush_valid", got_valid, 1'b0);
      chk("flush_ack", got_ack, 3'd0);
    end
    cyc(mk(2'b01, 32'h130C, 5'd7), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_run", got_ack, 3'd1);
    cyc('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_next", haddr(got_head), 32'h130C);

    // reset mid-stream
    cyc(mk(2'b01, 32'h1400, 5'd1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(mk(2'b01, 32'h1404, 5'd2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(mk(2'b01, 32'h1408, 5'd3), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mrst_ack", got_ack, 3'd0);
    chk("mrst_valid", got_valid, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mrst_empty", got_valid, 1'b0);
    cyc(mk(2'b01, 32'h1408, 5'd3), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mrst_ack_again", got_ack, 3'd1);

    // random traffic against the model
    cur = '0; cur_s = 1'b0; hold_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (got_ack != 3'd0 || cur[1:0] == 2'b00) begin
        cur = mk(2'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) != 0) ? {20'h00001, 12'($urandom)} : 32'($urandom),
                 5'($urandom));
        cur_s = 1'($urandom);
      end
      if ($urandom_range(0, 15) == 0) hold_r = ~hold_r;
      fl  = ($urandom_range(0, 40) == 0);
      rdy = 1'($urandom);
      cyc(cur, cur_s, hold_r, fl, rdy, 1'b1);
    end

`ifdef ROU_RX_STATS_EN
    cyc('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 70000; n++)
      cyc(mk(2'b01, 32'h1000, 5'd0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("stat_acc_sat", stat_acc, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
